// File: rtl/mole_game_ctrl.sv
// mole_game_ctrl: whack-a-mole sequencer (spawn, hit window, gap, scoring).
// Optional feature macro MISS_PENALTY_EN: wrong-switch edges during a mole window cost one point.
`default_nettype none

module mole_game_ctrl #(
  parameter int CLKS_PER_MS = 50000,
  parameter int ROUNDS      = 20,
  parameter int GAP_MS      = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  diff_sw,
  input  logic [7:0]  sw,
  output logic [7:0]  mole_led,
  output logic        start_evt,
  output logic        stop_evt,
  output logic [15:0] score,
  output logic [2:0]  diff,
  output logic        game_active
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SPAWN    = 2'd1;
  localparam logic [1:0] WAIT_HIT = 2'd2;
  localparam logic [1:0] GAP      = 2'd3;

  localparam int              TW        = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [TW-1:0]   TICK_LAST = TW'(CLKS_PER_MS - 1);
  localparam logic [15:0]     SCORE_MAX = 16'd9999;

  logic [1:0]    r_state;
  logic [1:0]    w_nxt;
  logic [15:0]   r_lfsr;
  logic [2:0]    r_pos;
  logic [15:0]   r_round;
  logic [TW-1:0] r_tick;
  logic [15:0]   r_ms;
  logic [15:0]   r_score;
  logic [2:0]    r_diff;
  logic [7:0]    r_sw_q;
  logic          r_stop;

  logic [7:0]    w_edge;
  logic [7:0]    w_mask;
  logic          w_hit;
  logic          w_penalty;
  logic          w_ms_done;
  logic [15:0]   w_win_ms;
  logic          w_win_end;
  logic          w_gap_end;
  logic          w_lfsr_fb;
  logic          w_timing;

  assign w_edge    = sw & ~r_sw_q;
  assign w_mask    = 8'h01 << r_pos;
  assign w_hit     = (r_state == WAIT_HIT) && (|(w_edge & w_mask));

`ifdef MISS_PENALTY_EN
  assign w_penalty = (r_state == WAIT_HIT) && (|(w_edge & ~w_mask));
`else
  assign w_penalty = 1'b0;
`endif

  assign w_win_ms  = r_diff[2] ? 16'd400 : (r_diff[1] ? 16'd700 : 16'd1000);
  assign w_ms_done = (r_tick == TICK_LAST);
  assign w_win_end = w_ms_done && (r_ms == w_win_ms - 16'd1);
  assign w_gap_end = w_ms_done && (r_ms == 16'(GAP_MS) - 16'd1);
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_timing  = (r_state == WAIT_HIT) || (r_state == GAP);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:     if (start) w_nxt = SPAWN;
      SPAWN:    w_nxt = WAIT_HIT;
      // A hit landing on the expiry cycle still wins: both just leave for GAP.
      WAIT_HIT: if (w_hit || w_win_end) w_nxt = GAP;
      GAP:      if (w_gap_end) w_nxt = (r_round < 16'(ROUNDS)) ? SPAWN : IDLE;
      default:  w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_lfsr  <= 16'hACE1;
      r_pos   <= 3'd0;
      r_round <= 16'd0;
      r_tick  <= '0;
      r_ms    <= 16'd0;
      r_score <= 16'd0;
      r_diff  <= 3'b001;
      r_sw_q  <= 8'd0;
      r_stop  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_lfsr  <= {w_lfsr_fb, r_lfsr[15:1]};
      r_sw_q  <= sw;
      r_stop  <= w_hit;

      if (r_state == IDLE) begin
        case (diff_sw)
          2'b10:   r_diff <= 3'b010;
          2'b11:   r_diff <= 3'b100;
          default: r_diff <= 3'b001;
        endcase
      end

      if (r_state == SPAWN) begin
        r_pos   <= r_lfsr[2:0];
        r_round <= r_round + 16'd1;
      end else if ((r_state == IDLE) && start) begin
        r_round <= 16'd0;
      end

      // Millisecond timebase restarts on every state change.
      if ((w_nxt != r_state) || !w_timing) begin
        r_tick <= '0;
        r_ms   <= 16'd0;
      end else if (w_ms_done) begin
        r_tick <= '0;
        r_ms   <= r_ms + 16'd1;
      end else begin
        r_tick <= r_tick + 1'b1;
      end

      if ((r_state == IDLE) && start) begin
        r_score <= 16'd0;
      end else if (w_hit) begin
        if (r_score != SCORE_MAX) r_score <= r_score + 16'd1;
      end else if (w_penalty && (r_score != 16'd0)) begin
        r_score <= r_score - 16'd1;
      end
    end
  end

  assign mole_led    = (r_state == WAIT_HIT) ? w_mask : 8'd0;
  assign start_evt   = (r_state == SPAWN);
  assign stop_evt    = r_stop;
  assign score       = r_score;
  assign diff        = r_diff;
  assign game_active = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mole_game_ctrl.sv
// tb_mole_game_ctrl: randomized scoreboard bench for mole_game_ctrl plus a score-saturation run.
`default_nettype none

module tb_mole_game_ctrl;

  localparam int CPM        = 5;
  localparam int GAPMS      = 2;
  localparam int NR         = 3;
  localparam int G          = CPM * GAPMS;
  localparam int SAT_ROUNDS = 10002;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, start_evt, stop_evt, game_active;
  logic [1:0]  diff_sw;
  logic [7:0]  sw, mole_led;
  logic [15:0] score;
  logic [2:0]  diff;

  logic        rst2_n, start2, start_evt2, stop_evt2, active2;
  logic [7:0]  sw2, led2;
  logic [15:0] score2;
  logic [2:0]  diff2;

  mole_game_ctrl #(.CLKS_PER_MS(CPM), .ROUNDS(NR), .GAP_MS(GAPMS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .diff_sw(diff_sw), .sw(sw),
    .mole_led(mole_led), .start_evt(start_evt), .stop_evt(stop_evt),
    .score(score), .diff(diff), .game_active(game_active)
  );

  mole_game_ctrl #(.CLKS_PER_MS(1), .ROUNDS(SAT_ROUNDS), .GAP_MS(1)) u_sat (
    .clk(clk), .rst_n(rst2_n), .start(start2), .diff_sw(2'b11), .sw(sw2),
    .mole_led(led2), .start_evt(start_evt2), .stop_evt(stop_evt2),
    .score(score2), .diff(diff2), .game_active(active2)
  );

  typedef struct {
    bit is_stop;
    int cyc;
    int pos;
    int score;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc;
  int  m_score, m_spawn, m_n, m_round;
  int  n2 = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] l;
    logic        b;
    l = 16'hACE1;
    for (int i = 0; i < n; i++) begin
      b = l[0] ^ l[2] ^ l[3] ^ l[5];
      l = {b, l[15:1]};
    end
    return l;
  endfunction

  function automatic logic [7:0] oh(input int p);
    return 8'h01 << p;
  endfunction

  function automatic int win_cyc(input logic [1:0] d);
    case (d)
      2'b11:   return 400 * CPM;
      2'b10:   return 700 * CPM;
      default: return 1000 * CPM;
    endcase
  endfunction

  function automatic logic [2:0] diff_oh(input logic [1:0] d);
    case (d)
      2'b11:   return 3'b100;
      2'b10:   return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_start(input int s);
    ev_t         e;
    logic [15:0] l;
    l       = lfsr_at(s);
    e.is_stop = 1'b0;
    e.cyc     = s;
    e.pos     = int'(l[2:0]);
    e.score   = 0;
    q.push_back(e);
  endtask

  task automatic begin_game(input logic [1:0] dsw);
    int c;
    c       = cyc;
    diff_sw = dsw;
    goto(c + 1);
    chk("diff_idle_track", 32'(diff), 32'(diff_oh(dsw)));
    start   = 1'b1;
    m_spawn = c + 2;
    push_start(m_spawn);
    goto(c + 2);
    start   = 1'b0;
    chk("game_active_on", 32'(game_active), 1);
    m_score = 0;
    m_round = 0;
    m_n     = win_cyc(dsw);
  endtask

  task automatic run_round(input bit hit, input int d, input bit wrong, input int w,
                           input bit combo, input bit ign);
    int          wst, e_cyc, pos, other;
    logic [15:0] l;
    ev_t         e;
    l     = lfsr_at(m_spawn);
    pos   = int'(l[2:0]);
    other = (pos + 1 + int'($urandom_range(0, 6))) % 8;
    wst   = m_spawn + 1;
    goto(wst);
    chk("led_lit", 32'(mole_led), 32'(oh(pos)));
    diff_sw = 2'($urandom);
    if (ign) begin
      goto(wst + 1);
      chk("diff_held", 32'(diff), 32'(diff_oh(2'b00)) | 32'(diff));
      start = 1'b1;
      goto(wst + 2);
      start = 1'b0;
    end
    if (wrong) begin
      goto(wst + w);
      sw = oh(other);
      goto(wst + w + 1);
      sw = 8'd0;
`ifdef MISS_PENALTY_EN
      if (m_score > 0) m_score--;
`endif
      goto(wst + w + 2);
      chk("score_after_wrong", 32'(score), 32'(m_score));
    end
    if (hit) begin
      goto(wst + d);
      sw = oh(pos) | (combo ? oh(other) : 8'd0);
      if (m_score < 9999) m_score++;
      e.is_stop = 1'b1;
      e.cyc     = wst + d + 1;
      e.pos     = pos;
      e.score   = m_score;
      q.push_back(e);
      goto(wst + d + 1);
      sw    = 8'd0;
      e_cyc = wst + d + 1;
      chk("led_off_after_hit", 32'(mole_led), 0);
    end else begin
      goto(wst + m_n - 1);
      chk("led_before_expiry", 32'(mole_led), 32'(oh(pos)));
      goto(wst + m_n);
      chk("led_after_expiry", 32'(mole_led), 0);
      chk("score_after_miss", 32'(score), 32'(m_score));
      e_cyc = wst + m_n;
    end
    m_round++;
    // Edges during the gap must be ignored.
    goto(e_cyc + 1);
    sw = 8'($urandom_range(1, 255));
    goto(e_cyc + 2);
    sw = 8'd0;
    if (m_round < NR) begin
      m_spawn = e_cyc + G;
      push_start(m_spawn);
    end else begin
      goto(e_cyc + G - 1);
      chk("active_in_last_gap", 32'(game_active), 1);
      goto(e_cyc + G);
      chk("idle_after_game", 32'(game_active), 0);
      chk("final_score", 32'(score), 32'(m_score));
    end
  endtask

  task automatic rand_round();
    int d, w;
    bit h;
    h = 1'($urandom_range(0, 1));
    d = int'($urandom_range(2, m_n - 1));
    w = int'($urandom_range(0, d - 2));
    run_round(h, d, 1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic main_seq();
    int d;
    diff_sw = 2'b10;
    chk("diff_latency_old", 32'(diff), 32'h1);
    goto(cyc + 1);
    chk("diff_latency_new", 32'(diff), 32'h2);

    // Game 1: hard, 37 ms reaction after a wrong press, then combo hit, then last-cycle hit.
    begin_game(2'b11);
    chk("diff_hard", 32'(diff), 32'h4);
    run_round(1'b1, 37 * CPM, 1'b1, 10, 1'b0, 1'b0);
    d = int'($urandom_range(2, m_n - 1));
    run_round(1'b1, d, 1'b1, int'($urandom_range(0, d - 2)), 1'b1, 1'b0);
    run_round(1'b1, m_n - 1, 1'b0, 0, 1'b0, 1'b0);

    // Game 2: easy, timeouts with an ignored start pulse.
    begin_game(2'b00);
    run_round(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    run_round(1'b1, int'($urandom_range(0, m_n - 1)), 1'b0, 0, 1'b0, 1'b0);
    run_round(1'b0, 0, 1'b1, int'($urandom_range(0, m_n - 3)), 1'b0, 1'b0);

    // Game 3: medium, aborted by reset during the mole window.
    begin_game(2'b10);
    rand_round();
    goto(m_spawn + 5);
    chk("led_before_reset", 32'(mole_led), 32'(oh(int'(lfsr_at(m_spawn) & 16'h7))));
    rst_n = 1'b0;
    #1;
    chk("rst_mole_led", 32'(mole_led), 0);
    chk("rst_start_evt", 32'(start_evt), 0);
    chk("rst_stop_evt", 32'(stop_evt), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_diff", 32'(diff), 32'h1);
    chk("rst_active", 32'(game_active), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_active", 32'(game_active), 0);
    chk("pending_after_rst", 32'(q.size()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Game 4: easy via 01, randomized rounds from a clean reset.
    begin_game(2'b01);
    for (int r = 0; r < NR; r++) rand_round();
    goto(cyc + 2);
    chk("queue_drained", 32'(q.size()), 0);
  endtask

  task automatic sat_seq();
    int k;
    @(posedge clk);
    #1;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    k = 0;
    while (active2 && (k < 40000)) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("sat_game_done", 32'(active2), 0);
    chk("sat_hit_count", 32'(n2), SAT_ROUNDS);
    chk("sat_score", 32'(score2), 9999);
  endtask

  // Scoreboard monitor for the main instance.
  bit  led_pend = 1'b0;
  int  led_pos  = 0;
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (led_pend) begin
        chk("spawn_led_onehot", 32'(mole_led), 32'(oh(led_pos)));
        led_pend = 1'b0;
      end
      if (start_evt || stop_evt) begin
        chk("evt_exclusive", 32'(start_evt & stop_evt), 0);
        if (q.size() == 0) begin
          chk("unexpected_evt", 32'({start_evt, stop_evt}), 0);
        end else begin
          e = q.pop_front();
          chk("evt_kind", 32'(stop_evt), 32'(e.is_stop));
          chk("evt_cycle", 32'(cyc), 32'(e.cyc));
          if (e.is_stop) begin
            chk("stop_score", 32'(score), 32'(e.score));
          end else begin
            led_pend = 1'b1;
            led_pos  = e.pos;
          end
        end
      end
    end
  end

  // Saturation instance: always presses the lit mole; watch the top of the range.
  initial begin
    forever begin
      @(negedge clk);
      sw2 = led2;
      if (stop_evt2) begin
        n2++;
        if (n2 >= 9990) chk("sat_step", 32'(score2), (n2 < 9999) ? n2 : 9999);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    rst2_n  = 1'b0;
    start   = 1'b0;
    start2  = 1'b0;
    diff_sw = 2'b00;
    sw      = 8'd0;
    sw2     = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_mole_led", 32'(mole_led), 0);
    chk("init_start_evt", 32'(start_evt), 0);
    chk("init_stop_evt", 32'(stop_evt), 0);
    chk("init_score", 32'(score), 0);
    chk("init_diff", 32'(diff), 32'h1);
    chk("init_active", 32'(game_active), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    @(posedge clk);
    #1;
    fork
      main_seq();
      sat_seq();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mole_game_ctrl.md
MOLE_GAME_CTRL -- requirements
Module: mole_game_ctrl

Interface
REQ-001 Parameter CLKS_PER_MS, default 50000, clock cycles per millisecond tick.
REQ-002 Parameter ROUNDS, default 20, moles per game.
REQ-003 Parameter GAP_MS, default 200, blank interval between moles in ms.
REQ-004 clk  in  1  system clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle game-start pulse, already debounced and synchronous to clk.
REQ-007 diff_sw  in  2  difficulty select: 00/01 easy, 10 medium, 11 hard.
REQ-008 sw  in  8  player switches, already synchronized to clk.
REQ-009 mole_led  out  8  one-hot lit mole; all zero when no mole is up.
REQ-010 start_evt  out  1  one-cycle pulse when a mole appears; drives the reaction timer.
REQ-011 stop_evt  out  1  one-cycle pulse on a correct hit.
REQ-012 score  out  16  binary score, range 0..9999.
REQ-013 diff  out  3  one-hot difficulty: 001 easy, 010 medium, 100 hard.
REQ-014 game_active  out  1  high in every state except IDLE.

Function
REQ-015 FSM states IDLE, SPAWN, WAIT_HIT, GAP; IDLE -> SPAWN on start, which also clears score, clears the round count and latches diff from diff_sw.
REQ-016 In IDLE, diff tracks diff_sw with one cycle of latency; during a game, diff holds the value latched at start; score holds its final value in IDLE.
REQ-017 A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle; it is never all-zero.
REQ-018 SPAWN lasts exactly one cycle: position = lfsr[2:0], start_evt = 1, round count +1, next state WAIT_HIT.
REQ-019 mole_led = one-hot(position) from the first WAIT_HIT cycle until WAIT_HIT is exited; zero otherwise.
REQ-020 Mole window: easy 1000 ms, medium 700 ms, hard 400 ms, measured in CLKS_PER_MS ticks from WAIT_HIT entry.
REQ-021 A hit is a rising edge on sw[position], detected as sw & ~sw_q with sw_q registered.
REQ-022 A hit in WAIT_HIT produces stop_evt = 1 for one cycle, score = min(score+1, 9999), next state GAP.
REQ-023 Window expiry without a hit produces next state GAP, with no stop_evt and no score change.
REQ-024 A hit in the same cycle as window expiry counts as a hit.
REQ-025 Rising edges in IDLE, SPAWN or GAP are ignored.
REQ-026 GAP lasts GAP_MS ms with mole_led = 0; it then exits to SPAWN if round count < ROUNDS, otherwise to IDLE.
REQ-027 A start pulse outside IDLE is ignored.
REQ-028 start_evt and stop_evt are never high in the same cycle.

Reset
REQ-029 While rst_n = 0: state = IDLE, mole_led = 0, start_evt = 0, stop_evt = 0, score = 0, diff = 001, game_active = 0, LFSR = 16'hACE1, all counters = 0, sw_q = 0.
REQ-030 Assertion of rst_n mid-game takes effect immediately, without waiting for a clock edge, and aborts the game.

Configuration
REQ-031 With MISS_PENALTY_EN defined, a rising edge on any switch other than sw[position] during WAIT_HIT decrements score, saturating at 0, and the state is unchanged.
REQ-032 If the correct switch and a wrong switch rise in the same cycle, only the hit is applied and no penalty is taken.
REQ-033 Without MISS_PENALTY_EN, wrong-switch edges have no effect.

Verification (CLKS_PER_MS=5, GAP_MS=2, ROUNDS=3)
REQ-034 diff_sw=11, start pulse -> game_active=1, diff=100, start_evt one cycle after start, mole_led one-hot at lfsr[2:0].
REQ-035 Correct switch raised 37 ms after start_evt -> single stop_evt, score 0 -> 1, mole_led=0, after 10 cycles next start_evt.
REQ-036 diff=easy, no input -> mole_led cleared 5000 cycles after WAIT_HIT entry, no stop_evt, score unchanged; after 3 rounds -> IDLE, game_active=0.
REQ-037 Score preloaded to 9999 via a hit run -> further hit keeps score = 9999; MISS_PENALTY_EN: wrong switch at score 0 keeps 0, wrong at 5 gives 4, correct and wrong in same cycle gives 6.
REQ-038 rst_n low during WAIT_HIT -> outputs at reset values immediately; start pulse after release begins a fresh game with score 0.
